// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and the
// multiply/divide busy tracker.
package hazard_pkg;

  typedef logic [1:0] tcycle_t;

  localparam tcycle_t    TUSE_NONE   = 2'd3;
  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_t;

  function automatic logic [3:0] md_load(input logic is_div);
    return is_div ? DIV_CYCLES : MULT_CYCLES;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Occupancy tracker for the multiply/divide unit: a start loads the latency,
// which then counts down to idle. A start while busy reloads the count.
module md_busy_counter
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  md_state_t  state;
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= 4'd0;
    end else if (start) begin
      state <= MD_BUSY;
      cnt   <= md_load(is_div);
    end else if (state == MD_BUSY) begin
      if (cnt <= 4'd1) begin
        cnt   <= 4'd0;
        state <= MD_IDLE;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // A start counts as busy in its own cycle, before the count is loaded.
  assign busy = !reset && (start || (state == MD_BUSY));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush control for the five-stage pipeline: Tuse/Tnew data hazards
// plus multiply/divide occupancy. Define STALL_PERF_EN to add stall_cnt.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  tcycle_t     D_tuse_rs,
  input  tcycle_t     D_tuse_rt,
  input  logic [4:0]  E_wa,
  input  logic [4:0]  M_wa,
  input  tcycle_t     E_tnew,
  input  tcycle_t     M_tnew,
  input  logic        D_is_md,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  output logic        F_WE,
  output logic        D_WE,
  output logic        E_flush,
  output logic        M_WE,
  output logic        W_WE,
  output logic        md_busy
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  function automatic logic src_hazard(input logic [4:0] addr, input tcycle_t tuse,
                                      input logic [4:0] e_wa, input tcycle_t e_tnew,
                                      input logic [4:0] m_wa, input tcycle_t m_tnew);
    return (addr != 5'd0) && (tuse != TUSE_NONE) &&
           (((addr == e_wa) && (tuse < e_tnew)) || ((addr == m_wa) && (tuse < m_tnew)));
  endfunction

  logic rs_hazard;
  logic rt_hazard;
  logic md_hazard;
  logic stall;

  md_busy_counter u_md_busy (
    .clk    (clk),
    .reset  (reset),
    .start  (E_md_start),
    .is_div (E_md_is_div),
    .busy   (md_busy)
  );

  assign rs_hazard = src_hazard(D_rs_addr, D_tuse_rs, E_wa, E_tnew, M_wa, M_tnew);
  assign rt_hazard = src_hazard(D_rt_addr, D_tuse_rt, E_wa, E_tnew, M_wa, M_tnew);
  assign md_hazard = D_is_md && md_busy;

  // Reset forces the pipeline to run freely with no bubbles.
  assign stall   = !reset && (rs_hazard || rt_hazard || md_hazard);
  assign F_WE    = !stall;
  assign D_WE    = !stall;
  assign E_flush = stall;
  assign M_WE    = 1'b1;
  assign W_WE    = 1'b1;

`ifdef STALL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table of single-cycle hazard vectors plus
// multi-cycle multiply/divide and reset sequences, checked via a scoreboard.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs_addr, D_rt_addr, E_wa, M_wa;
  logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic        D_is_md, E_md_start, E_md_is_div;
  logic        F_WE, D_WE, E_flush, M_WE, W_WE, md_busy;
`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .D_rs_addr   (D_rs_addr),
    .D_rt_addr   (D_rt_addr),
    .D_tuse_rs   (D_tuse_rs),
    .D_tuse_rt   (D_tuse_rt),
    .E_wa        (E_wa),
    .M_wa        (M_wa),
    .E_tnew      (E_tnew),
    .M_tnew      (M_tnew),
    .D_is_md     (D_is_md),
    .E_md_start  (E_md_start),
    .E_md_is_div (E_md_is_div),
    .F_WE        (F_WE),
    .D_WE        (D_WE),
    .E_flush     (E_flush),
    .M_WE        (M_WE),
    .W_WE        (W_WE),
    .md_busy     (md_busy)
`ifdef STALL_PERF_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [4:0] e_wa;
    logic [1:0] e_tnew;
    logic [4:0] m_wa;
    logic [1:0] m_tnew;
    logic       is_md;
    logic       stall;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] exp;
  } sb_t;

  sb_t  sb[$];
  vec_t vt[12];
  int   vectors     = 0;
  int   miscompares = 0;

  // Expected {F_WE, D_WE, E_flush, M_WE, W_WE, md_busy}.
  function automatic logic [5:0] outs(input logic stall, input logic busy);
    return {~stall, ~stall, stall, 1'b1, 1'b1, busy};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    D_rs_addr   = 5'd0;
    D_rt_addr   = 5'd0;
    D_tuse_rs   = TUSE_NONE;
    D_tuse_rt   = TUSE_NONE;
    E_wa        = 5'd0;
    M_wa        = 5'd0;
    E_tnew      = 2'd0;
    M_tnew      = 2'd0;
    D_is_md     = 1'b0;
    E_md_start  = 1'b0;
    E_md_is_div = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    D_rs_addr = v.rs;
    D_rt_addr = v.rt;
    D_tuse_rs = v.tuse_rs;
    D_tuse_rt = v.tuse_rt;
    E_wa      = v.e_wa;
    E_tnew    = v.e_tnew;
    M_wa      = v.m_wa;
    M_tnew    = v.m_tnew;
    D_is_md   = v.is_md;
  endtask

  // Push the expectation for this cycle, then compare at the falling edge.
  task automatic expect_out(input string name, input logic [5:0] exp);
    sb_t        e;
    logic [5:0] act;
    sb.push_back('{name, exp});
    @(negedge clk);
    e   = sb.pop_front();
    act = {F_WE, D_WE, E_flush, M_WE, W_WE, md_busy};
    vectors++;
    if (act !== e.exp) begin
      miscompares++;
      $display("FAIL %s: got {F,D,flush,M,W,busy}=%b, expected %b", e.name, act, e.exp);
    end
  endtask

`ifdef STALL_PERF_EN
  task automatic check_cnt(input string name, input logic [31:0] exp);
    vectors++;
    if (stall_cnt !== exp) begin
      miscompares++;
      $display("FAIL %s: stall_cnt=%0h, expected %0h", name, stall_cnt, exp);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            rs     rt     trs   trt   e_wa   etn   m_wa   mtn   md    stall
    vt[0]  = '{5'd5, 5'd0, 2'd0, 2'd3, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 1'b1};
    vt[1]  = '{5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 5'd5, 2'd1, 1'b0, 1'b1};
    vt[2]  = '{5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd2, 5'd0, 2'd1, 1'b0, 1'b0};
    vt[3]  = '{5'd0, 5'd0, 2'd3, 2'd0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0};
    vt[4]  = '{5'd5, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2, 5'd5, 2'd2, 1'b0, 1'b0};
    vt[5]  = '{5'd0, 5'd7, 2'd3, 2'd1, 5'd7, 2'd2, 5'd0, 2'd0, 1'b0, 1'b1};
    vt[6]  = '{5'd0, 5'd7, 2'd3, 2'd1, 5'd7, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0};
    vt[7]  = '{5'd9, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 5'd9, 2'd1, 1'b0, 1'b0};
    vt[8]  = '{5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd2, 5'd0, 2'd2, 1'b0, 1'b0};
    vt[9]  = '{5'd3, 5'd4, 2'd0, 2'd0, 5'd4, 2'd1, 5'd0, 2'd0, 1'b0, 1'b1};
    vt[10] = '{5'd3, 5'd0, 2'd0, 2'd3, 5'd3, 2'd0, 5'd3, 2'd0, 1'b0, 1'b0};
    vt[11] = '{5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0};

    // Reset with hazardous inputs present: everything must run freely.
    reset = 1'b1;
    idle_inputs();
    D_rs_addr  = 5'd5;
    D_tuse_rs  = 2'd0;
    E_wa       = 5'd5;
    E_tnew     = 2'd2;
    D_is_md    = 1'b1;
    E_md_start = 1'b1;
    expect_out("reset_outputs", outs(1'b0, 1'b0));
`ifdef STALL_PERF_EN
    check_cnt("reset_stall_cnt", 32'd0);
`endif
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    expect_out("after_reset", outs(1'b0, 1'b0));

    for (int i = 0; i < 12; i++) begin
      next_cycle();
      apply_vec(vt[i]);
      expect_out($sformatf("tbl%0d", i), outs(vt[i].stall, 1'b0));
    end

    // Load-use: lw in E, then in M, then gone.
    next_cycle();
    idle_inputs();
    D_rs_addr = 5'd5; D_tuse_rs = 2'd0; E_wa = 5'd5; E_tnew = 2'd2;
    expect_out("lw_in_E", outs(1'b1, 1'b0));
    next_cycle();
    E_wa = 5'd0; E_tnew = 2'd0; M_wa = 5'd5; M_tnew = 2'd1;
    expect_out("lw_in_M", outs(1'b1, 1'b0));
    next_cycle();
    M_wa = 5'd0; M_tnew = 2'd0;
    expect_out("lw_done", outs(1'b0, 1'b0));

    // mult start in cycle 0 with an md instruction waiting in D.
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      idle_inputs();
      D_is_md    = 1'b1;
      E_md_start = (k == 0);
      expect_out($sformatf("mult_c%0d", k), outs(k <= 5, k <= 5));
    end

    // Restart in cycle 2 reloads: busy through cycle 7.
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      idle_inputs();
      E_md_start = (k == 0) || (k == 2);
      expect_out($sformatf("restart_c%0d", k), outs(1'b0, k <= 7));
    end

    // div start, reset at cycle 4, no resumption after release.
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      idle_inputs();
      D_is_md     = 1'b1;
      E_md_start  = (k == 0);
      E_md_is_div = 1'b1;
      reset       = (k == 4);
      expect_out($sformatf("divrst_c%0d", k), outs(k < 4, k < 4));
    end

`ifdef STALL_PERF_EN
    next_cycle();
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      D_rs_addr = 5'd5; D_tuse_rs = 2'd0; E_wa = 5'd5; E_tnew = 2'd2;
      expect_out($sformatf("perf_stall%0d", k), outs(1'b1, 1'b0));
    end
    next_cycle();
    idle_inputs();
    expect_out("perf_idle", outs(1'b0, 1'b0));
    check_cnt("stall_cnt_3", 32'd3);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    next_cycle();
    D_rs_addr = 5'd5; D_tuse_rs = 2'd0; E_wa = 5'd5; E_tnew = 2'd2;
    expect_out("perf_wrap_stall", outs(1'b1, 1'b0));
    next_cycle();
    idle_inputs();
    expect_out("perf_wrap_idle", outs(1'b0, 1'b0));
    check_cnt("stall_cnt_wrap", 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have ports D_rs_addr, D_rt_addr, input, 5 each: source register numbers of the instruction in D.
REQ-004 SHALL have ports D_tuse_rs, D_tuse_rt, input, 2 each: cycles until the operand is needed (0..2); 3 = operand unused.
REQ-005 SHALL have ports E_wa, M_wa, input, 5 each: destination register of the instructions in E and M; 0 = no write.
REQ-006 SHALL have ports E_tnew, M_tnew, input, 2 each: cycles until the result is produced, counted from the current stage.
REQ-007 SHALL have port D_is_md, input, 1: the D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 SHALL have ports E_md_start, E_md_is_div, input, 1 each: the E instruction starts mult (is_div=0) or div (is_div=1) this cycle.
REQ-009 SHALL have ports F_WE, D_WE, output, 1 each: write enables of the PC and of the F/D register.
REQ-010 SHALL have port E_flush, output, 1: loads a bubble (all-zero instr/pc) into the D/E register.
REQ-011 SHALL have ports M_WE, W_WE, output, 1 each: write enables of the E/M and M/W registers.
REQ-012 SHALL have port md_busy, output, 1: the multiply/divide unit is occupied.

Function
REQ-013 SHALL flag an rs hazard when D_rs_addr!=0 and either (D_rs_addr==E_wa and D_tuse_rs<E_tnew) or (D_rs_addr==M_wa and D_tuse_rs<M_tnew); rt is checked identically.
REQ-014 SHALL ignore matches against register 0 and never stall when tuse==3.
REQ-015 SHALL hold a 4-bit busy counter; FSM states IDLE (cnt==0) and BUSY (cnt!=0).
REQ-016 SHALL load cnt with MULT_CYCLES=5 or DIV_CYCLES=10 on the posedge following E_md_start=1, regardless of state; a restart while BUSY reloads.
REQ-017 SHALL otherwise decrement cnt by 1 per cycle in BUSY, saturating at 0, and return to IDLE when cnt reaches 0.
REQ-018 SHALL drive md_busy = E_md_start | (cnt!=0), combinationally.
REQ-019 SHALL flag an md hazard when D_is_md & md_busy.
REQ-020 SHALL compute stall = rs hazard | rt hazard | md hazard, combinationally, with zero-cycle latency.
REQ-021 SHALL drive F_WE=D_WE=!stall, E_flush=stall, M_WE=W_WE=1 at all times when not in reset.
REQ-022 SHALL give the data hazards and the md hazard equal priority; any single source asserts the stall.

Reset
REQ-023 SHALL clear cnt to 0 (IDLE) immediately on reset assertion, including mid-BUSY; no resumption after release.
REQ-024 SHALL, while reset=1, drive F_WE=D_WE=M_WE=W_WE=1, E_flush=0, md_busy=0, stall count 0.

Configuration
REQ-025 SHALL, with STALL_PERF_EN defined, add output stall_cnt, 32-bit: increments on each posedge with stall=1, wraps 0xFFFFFFFF->0, cleared by reset.
REQ-026 SHALL, without STALL_PERF_EN, omit stall_cnt entirely; all other behaviour is identical.

Structure
REQ-027 SHALL take MULT_CYCLES, DIV_CYCLES, TUSE_NONE=3 and the 2-bit tuse/tnew type from shared package hazard_pkg.
REQ-028 SHALL place the busy counter/FSM in sub-module md_busy_counter; hazard comparison remains in hazard_ctrl.

Verification
REQ-029 SHALL cover: E_wa=5, E_tnew=2 (lw), D_rs_addr=5, D_tuse_rs=0 -> stall: F_WE=0, D_WE=0, E_flush=1; next cycle M_tnew=1 -> still stall; then clear.
REQ-030 SHALL cover: D_rt_addr=0, E_wa=0, E_tnew=2 -> no stall; D_tuse_rs=3 with a matching E_wa -> no stall.
REQ-031 SHALL cover: E_md_start=1, E_md_is_div=0 at cycle 0, D_is_md=1 -> stall in cycles 0..5; F_WE=1 in cycle 6.
REQ-032 SHALL cover: div start followed by reset at cycle 4 -> md_busy=0 immediately; no stall after reset release.
REQ-033 SHALL cover: mult start, then a second start in cycle 2 -> cnt reloads to 5; md_busy stays high through cycle 7.
REQ-034 SHALL cover, with STALL_PERF_EN: 3 stall cycles -> stall_cnt=3; preload 0xFFFFFFFF plus one stall -> 0.
